// File: rtl/uart_line_ctrl_pkg.sv
// rtl/uart_line_ctrl_pkg.sv - shared ASCII codes and state encodings for the UART line controller
package uart_line_ctrl_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;

  typedef enum logic {
    COLLECT,
    READY
  } line_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT,
    TX_BUSY
  } tx_state_e;

endpackage

// File: rtl/uart_line_ctrl_fifo.sv
// rtl/uart_line_ctrl_fifo.sv - synchronous FIFO with registered pointers, used for the echo queue
module uart_line_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_pop_data = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/uart_line_ctrl.sv
// rtl/uart_line_ctrl.sv - RX line assembly with echo, and round-robin UART TX arbitration echo vs CPU
module uart_line_ctrl
  import uart_line_ctrl_pkg::*;
#(
  parameter int  LINE_MAX   = 16,
  parameter int  ECHO_DEPTH = 4,
  parameter bit  ECHO_EN    = 1'b1,
  localparam int LW         = $clog2(LINE_MAX + 1),
  localparam int AW         = $clog2(LINE_MAX)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_start,
  input  logic          i_tx_busy,
  input  logic [7:0]    i_cpu_tx_data,
  input  logic          i_cpu_tx_req,
  output logic          o_cpu_tx_ack,
  output logic          o_line_ready,
  output logic [LW-1:0] o_line_len,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  input  logic          i_line_ack,
  output logic          o_overflow
);

  localparam logic [LW-1:0] LEN_MAX = LW'(LINE_MAX);

  line_state_e   r_line_state, w_line_next;
  logic [LW-1:0] r_len;
  logic [7:0]    r_buf [LINE_MAX];
  logic          r_overflow;
  logic [7:0]    r_rd_data;
  logic          w_store, w_len_inc, w_len_dec, w_len_clr, w_ovf_set, w_ovf_clr, w_echo;

  tx_state_e     r_tx_state, w_tx_next;
  logic          r_rr_cpu;
  logic [7:0]    r_tx_data;
  logic          w_grant_cpu, w_grant_echo, w_tx_start;
  logic [7:0]    w_tx_byte, w_fifo_data;
  logic          w_fifo_full, w_fifo_empty;

  always_comb begin
    w_line_next = r_line_state;
    w_store     = 1'b0;
    w_len_inc   = 1'b0;
    w_len_dec   = 1'b0;
    w_len_clr   = 1'b0;
    w_ovf_set   = 1'b0;
    w_ovf_clr   = 1'b0;
    w_echo      = 1'b0;
    case (r_line_state)
      COLLECT: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            ASCII_LF: if (r_len != '0) w_line_next = READY;
            ASCII_CR: ;
            ASCII_BS: if (r_len != '0) begin
              w_len_dec = 1'b1;
              w_echo    = 1'b1;
            end
            default: if (r_len < LEN_MAX) begin
              w_store   = 1'b1;
              w_len_inc = 1'b1;
              w_echo    = 1'b1;
            end else begin
              w_ovf_set = 1'b1;
            end
          endcase
        end
      end
      READY: begin
        // Ack clear takes precedence over a byte arriving in the same cycle
        if (i_line_ack) begin
          w_len_clr   = 1'b1;
          w_ovf_clr   = 1'b1;
          w_line_next = COLLECT;
        end else if (i_rx_valid) begin
          w_ovf_set = 1'b1;
        end
      end
      default: w_line_next = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_line_state <= COLLECT;
    else         r_line_state <= w_line_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len      <= '0;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_len_clr)      r_len <= '0;
      else if (w_len_inc) r_len <= r_len + 1'b1;
      else if (w_len_dec) r_len <= r_len - 1'b1;
      if (w_ovf_clr)      r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
      r_rd_data <= r_buf[i_rd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_store) r_buf[r_len[AW-1:0]] <= i_rx_data;
  end

  uart_line_ctrl_fifo #(.WIDTH(8), .DEPTH(ECHO_DEPTH)) u_echo_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_echo && ECHO_EN),
    .i_push_data (i_rx_data),
    .i_pop       (w_grant_echo),
    .o_pop_data  (w_fifo_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_comb begin
    w_tx_next    = r_tx_state;
    w_grant_cpu  = 1'b0;
    w_grant_echo = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!i_tx_busy && !i_reset) begin
          if (i_cpu_tx_req && (w_fifo_empty || r_rr_cpu)) begin
            w_grant_cpu = 1'b1;
            w_tx_next   = TX_WAIT;
          end else if (!w_fifo_empty) begin
            w_grant_echo = 1'b1;
            w_tx_next    = TX_WAIT;
          end
        end
      end
      TX_WAIT: if (i_tx_busy)  w_tx_next = TX_BUSY;
      TX_BUSY: if (!i_tx_busy) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  assign w_tx_start = w_grant_cpu || w_grant_echo;
  assign w_tx_byte  = w_grant_cpu ? i_cpu_tx_data : w_fifo_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_state <= TX_IDLE;
      r_rr_cpu   <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      // Priority passes to the requester that was not just served
      if (w_tx_start) begin
        r_tx_data <= w_tx_byte;
        r_rr_cpu  <= w_grant_echo;
      end
    end
  end

  assign o_tx_start   = w_tx_start;
  assign o_tx_data    = w_tx_start ? w_tx_byte : r_tx_data;
  assign o_cpu_tx_ack = w_grant_cpu;
  assign o_line_ready = (r_line_state == READY);
  assign o_line_len   = r_len;
  assign o_rd_data    = r_rd_data;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_uart_line_ctrl.sv
// tb/tb_uart_line_ctrl.sv - directed scoreboard bench for uart_line_ctrl with a simple UART TX model
module tb_uart_line_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] cpu_tx_data;
  logic       cpu_tx_req;
  logic       cpu_tx_ack;
  logic       line_ready;
  logic [4:0] line_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       line_ack;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_line_ctrl #(.LINE_MAX(16), .ECHO_DEPTH(4), .ECHO_EN(1'b1)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_busy    (tx_busy),
    .i_cpu_tx_data(cpu_tx_data),
    .i_cpu_tx_req (cpu_tx_req),
    .o_cpu_tx_ack (cpu_tx_ack),
    .o_line_ready (line_ready),
    .o_line_len   (line_len),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .i_line_ack   (line_ack),
    .o_overflow   (overflow)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART TX model: busy rises one cycle after a launch and lasts three cycles
  logic stall = 1'b0;
  logic hold  = 1'b0;
  logic start_d = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (start_d)  busy_cnt <= 3;
    start_d <= tx_start && !stall;
  end
  assign tx_busy = (busy_cnt != 0) || hold;

  // Scoreboard entries are {cpu_ack, byte}
  logic [8:0] sb_q[$];
  logic       seen_busy = 1'b1;
  always @(negedge clk) begin
    logic [15:0] exp;
    if (tx_busy) seen_busy = 1'b1;
    if (tx_start) begin
      check("tx_busy_between_starts", {15'd0, seen_busy}, 16'd1);
      seen_busy = 1'b0;
      exp = (sb_q.size() != 0) ? {7'd0, sb_q.pop_front()} : 16'hFFFF;
      check("tx_launch", {7'd0, cpu_tx_ack, tx_data}, exp);
    end
  end

  int m_len = 0;
  bit m_ready = 1'b0;
  bit m_ovf = 1'b0;
  bit m_echo_drop = 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_echo(input logic [7:0] b);
    if (!m_echo_drop) sb_q.push_back({1'b0, b});
  endtask

  task automatic rx_byte(input logic [7:0] b, input int gap);
    if (m_ready) m_ovf = 1'b1;
    else if (b == 8'h0A) begin
      if (m_len > 0) m_ready = 1'b1;
    end else if (b == 8'h08) begin
      if (m_len > 0) begin
        m_len--;
        push_echo(8'h08);
      end
    end else if (b != 8'h0D) begin
      if (m_len < 16) begin
        m_len++;
        push_echo(b);
      end else m_ovf = 1'b1;
    end
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_line(input string tag);
    check({tag, "_ready"}, {15'd0, line_ready}, {15'd0, m_ready});
    check({tag, "_len"}, {11'd0, line_len}, 16'(m_len));
    check({tag, "_ovf"}, {15'd0, overflow}, {15'd0, m_ovf});
  endtask

  task automatic read_byte(input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    check("rd_data", {8'd0, rd_data}, {8'd0, exp});
  endtask

  task automatic ack_line;
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    m_ready = 1'b0;
    m_len = 0;
    m_ovf = 1'b0;
  endtask

  task automatic drain;
    repeat (40) tick();
    check("scoreboard_empty", 16'(sb_q.size()), 16'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    check("rst_tx_start", {15'd0, tx_start}, 16'd0);
    check("rst_tx_data", {8'd0, tx_data}, 16'd0);
    check("rst_cpu_ack", {15'd0, cpu_tx_ack}, 16'd0);
    check("rst_line_ready", {15'd0, line_ready}, 16'd0);
    check("rst_line_len", {11'd0, line_len}, 16'd0);
    check("rst_rd_data", {8'd0, rd_data}, 16'd0);
    check("rst_overflow", {15'd0, overflow}, 16'd0);
    sb_q.delete();
    seen_busy = 1'b1;
    m_len = 0;
    m_ready = 1'b0;
    m_ovf = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_cpu_ack(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (cpu_tx_ack) got = 1'b1;
    end
    tick();
    check(tag, {15'd0, got}, 16'd1);
  endtask

  initial begin
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; cpu_tx_data = '0;
    cpu_tx_req = 1'b0; rd_addr = '0; line_ack = 1'b0;
    tick();
    do_reset();

    // Basic line with trailing CR arriving after the line is ready
    for (int i = 0; i < 4; i++) rx_byte(8'h34 + 8'(i), 6);
    rx_byte(8'h0A, 1);
    rx_byte(8'h0D, 1);
    check_line("t1");
    for (int i = 0; i < 4; i++) read_byte(4'(i), 8'h34 + 8'(i));
    drain();

    // Drop while ready, ack, second line, ack racing a byte
    rx_byte(8'h39, 1);
    check_line("t2_drop");
    ack_line();
    check_line("t2_ack");
    rx_byte(8'h39, 6);
    rx_byte(8'h0A, 1);
    check_line("t2_line");
    read_byte(4'd0, 8'h39);
    rx_data = 8'h40; rx_valid = 1'b1;
    ack_line();
    rx_valid = 1'b0;
    check_line("t2_ack_race");
    drain();

    // Backspace editing, then backspace on an empty line
    rx_byte(8'h31, 6); rx_byte(8'h32, 6); rx_byte(8'h08, 6); rx_byte(8'h33, 6);
    rx_byte(8'h0A, 1);
    check_line("t3");
    read_byte(4'd0, 8'h31);
    read_byte(4'd1, 8'h33);
    ack_line();
    rx_byte(8'h08, 6);
    check_line("t3_bs_empty");
    drain();

    // Line full then overflow, ack ignored in COLLECT, lone LF
    for (int i = 0; i < 16; i++) rx_byte(8'h41, 6);
    check_line("t4_full");
    rx_byte(8'h41, 6);
    check_line("t4_ovf");
    read_byte(4'd15, 8'h41);
    rx_byte(8'h0A, 1);
    check_line("t4_ready");
    ack_line();
    rx_byte(8'h41, 6);
    line_ack = 1'b1; tick(); line_ack = 1'b0;
    check_line("t4_ack_collect");
    rx_byte(8'h08, 6);
    rx_byte(8'h0A, 6);
    check_line("t4_lone_lf");
    drain();

    // Echo FIFO full: fifth echo lost but the byte is still stored
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_echo_drop = (i == 4);
      rx_byte(8'h61 + 8'(i), 1);
    end
    m_echo_drop = 1'b0;
    check_line("t5_fifo_full");
    read_byte(4'd4, 8'h65);
    hold = 1'b0;
    drain();
    rx_byte(8'h0A, 1);
    ack_line();

    // Arbitration: both pending, pointer favours CPU after the last echo grant
    hold = 1'b1;
    m_echo_drop = 1'b1;
    rx_byte(8'h31, 1);
    rx_byte(8'h32, 1);
    m_echo_drop = 1'b0;
    sb_q.push_back({1'b1, 8'h52});
    sb_q.push_back({1'b0, 8'h31});
    sb_q.push_back({1'b1, 8'h53});
    sb_q.push_back({1'b0, 8'h32});
    cpu_tx_data = 8'h52; cpu_tx_req = 1'b1;
    tick();
    hold = 1'b0;
    wait_cpu_ack("t6_cpu_ack1");
    cpu_tx_data = 8'h53;
    wait_cpu_ack("t6_cpu_ack2");
    cpu_tx_req = 1'b0;
    drain();
    rx_byte(8'h0A, 1);
    check_line("t6_line");
    ack_line();

    // Reset while TX waits for busy, then reset while a line is ready
    stall = 1'b1;
    rx_byte(8'h41, 0);
    rx_byte(8'h42, 2);
    do_reset();
    stall = 1'b0;
    rx_byte(8'h41, 6); rx_byte(8'h42, 6); rx_byte(8'h0A, 10);
    rx_byte(8'h5A, 1);
    check_line("t7_ready");
    do_reset();
    rx_byte(8'h43, 6); rx_byte(8'h44, 6); rx_byte(8'h0A, 1);
    check_line("t7_after");
    read_byte(4'd0, 8'h43);
    read_byte(4'd1, 8'h44);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
